dct8_mac_accum: RTL and testbench

DCT8_MAC_ACCUM -- requirements
Module: dct8_mac_accum

---
 rtl/dct_fixed_pkg.sv | 8 +
 rtl/dct8_mac_accum_q16_mul.sv | 23 ++
 rtl/dct8_mac_accum.sv | 79 +++++++
 tb/tb_dct8_mac_accum.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/dct_fixed_pkg.sv
// dct_fixed_pkg: shared Q16.16 constants and MAC state type
package dct_fixed_pkg;
  localparam int Q_FRAC = 16;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] Q_MIN = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} mac_state_e;
endpackage

// File: rtl/dct8_mac_accum_q16_mul.sv
// q16_mul: combinational Q16.16 sign-magnitude multiply truncating toward zero
//   a, b : signed Q16.16 operands
//   p    : signed Q16.16 product
module q16_mul
  import dct_fixed_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] p
);
  localparam int PW = DATA_W + Q_FRAC;
  logic [DATA_W-1:0] ma, mb, mag;
  logic [PW-1:0] prod;
  always_comb begin
    // -2^31 negates to itself, which read unsigned is the magnitude 2^31
    ma = a[DATA_W-1] ? -a : a;
    mb = b[DATA_W-1] ? -b : b;
    // only product bits [47:16] are kept, so a 48-bit product suffices
    prod = PW'(ma) * PW'(mb);
    mag = DATA_W'(prod >> Q_FRAC);
    p = (a[DATA_W-1] ^ b[DATA_W-1]) ? -mag : mag;
  end
endmodule

// File: rtl/dct8_mac_accum.sv
// dct8_mac_accum: N_TERMS-term Q16.16 multiply-accumulate with valid/ready handshakes
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : term handshake, operands in_a, in_b (Q16.16)
//   out_valid/out_ready : result handshake, out_sum (Q16.16), out_ovf
//   MAC_SATURATE_EN     : when defined, out_sum clamps on overflow instead of wrapping
module dct8_mac_accum
  import dct_fixed_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf
);
  localparam int CW = $clog2(N_TERMS);
  mac_state_e state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d, sum_nx, prod;
  logic ovf_q, ovf_d, ovf_nx;
  logic [ACC_W-DATA_W:0] top_bits;
  q16_mul u_mul (.a(in_a), .b(in_b), .p(prod));
  assign in_ready = state_q != HOLD;
  assign out_valid = state_q == HOLD;
  assign out_sum = sum_q;
  assign out_ovf = ovf_q;
  always_comb begin
    acc_nx = acc_q + {{(ACC_W-DATA_W){prod[DATA_W-1]}}, prod};
    // the sum fits signed 32 bits only if bit 31 and everything above agree
    top_bits = acc_nx[ACC_W-1:DATA_W-1];
    ovf_nx = |top_bits && !(&top_bits);
`ifdef MAC_SATURATE_EN
    sum_nx = ovf_nx ? (acc_nx[ACC_W-1] ? Q_MIN : Q_MAX) : acc_nx[DATA_W-1:0];
`else
    sum_nx = acc_nx[DATA_W-1:0];
`endif
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (state_q == HOLD) begin
      if (out_ready) begin
        state_d = IDLE;
        acc_d = '0;
        cnt_d = '0;
      end
    end else if (in_valid) begin
      acc_d = acc_nx;
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(N_TERMS - 1)) ? HOLD : ACCUM;
      sum_d = (cnt_q == CW'(N_TERMS - 1)) ? sum_nx : sum_q;
      ovf_d = (cnt_q == CW'(N_TERMS - 1)) ? ovf_nx : ovf_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_dct8_mac_accum.sv
// tb_dct8_mac_accum: table-driven scoreboard bench for dct8_mac_accum
module tb_dct8_mac_accum;
  typedef struct {
    logic [7:0][31:0] a;
    logic [7:0][31:0] b;
    logic [31:0]      sum;
    logic             ovf;
  } vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_ovf;
  logic [31:0] in_a = 0, in_b = 0, out_sum;
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [32:0] sbq[$];
  int hs_cyc[$];
  vec_t tbl[7];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dct8_mac_accum dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  function automatic vec_t model(input vec_t v);
    longint s = 0;
    longint p;
    logic [31:0] pw;
    vec_t r = v;
    for (int i = 0; i < 8; i++) begin
      p = (longint'($signed(v.a[i])) * longint'($signed(v.b[i]))) / 65536;
      pw = p[31:0];
      s += longint'($signed(pw));
    end
    r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    r.sum = s[31:0];
`ifdef MAC_SATURATE_EN
    if (r.ovf) r.sum = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return r;
  endfunction
  function automatic vec_t fill(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sum, input logic ovf);
    vec_t v;
    for (int i = 0; i < 8; i++) begin
      v.a[i] = a;
      v.b[i] = b;
    end
    v.sum = sum;
    v.ovf = ovf;
    return v;
  endfunction
  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
  endtask
  task automatic send(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      wait_ready();
      in_valid = 1;
      in_a = v.a[i];
      in_b = v.b[i];
      @(posedge clk); #1;
    end
    in_valid = 0;
    sbq.push_back({v.ovf, v.sum});
    chk("out_valid_latency", {31'b0, out_valid}, 32'd1);
  endtask
  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("scoreboard_drain", sbq.size(), 0);
  endtask
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      if (sbq.size() == 0) chk("unexpected_result", out_sum, 32'hxxxx_xxxx);
      else begin
        chk("out_sum", out_sum, sbq[0][31:0]);
        chk("out_ovf", {31'b0, out_ovf}, {31'b0, sbq[0][32]});
        void'(sbq.pop_front());
      end
    end
  end
  initial begin
    vec_t v;
    logic [31:0] held;
    tbl[0] = fill(32'h0001_0000, 32'h0000_8000, 32'h0004_0000, 1'b0);
    tbl[1] = fill(32'hFFFE_8000, 32'h0002_0000, 32'hFFE8_0000, 1'b0);
    tbl[2] = fill(32'h0000_0001, 32'h0000_8000, 32'h0000_0000, 1'b0);
    for (int i = 1; i < 8; i += 2) tbl[2].a[i] = 32'hFFFF_FFFF;
`ifdef MAC_SATURATE_EN
    tbl[3] = fill(32'h7FFF_0000, 32'h0001_0000, 32'h7FFF_FFFF, 1'b1);
`else
    tbl[3] = fill(32'h7FFF_0000, 32'h0001_0000, 32'hFFF8_0000, 1'b1);
`endif
    tbl[4] = fill(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);
    for (int k = 5; k < 7; k++) begin
      for (int i = 0; i < 8; i++) begin
        tbl[k].a[i] = $urandom;
        tbl[k].b[i] = $urandom_range(32'h0004_0000, 0) - 32'h0002_0000;
      end
      tbl[k] = model(tbl[k]);
    end
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("in_ready_after_reset", {31'b0, in_ready}, 32'd1);
    for (int k = 0; k < 7; k++) send(tbl[k]);
    drain();
    chk("throughput_gap", hs_cyc[1] - hs_cyc[0], 32'd9);
    chk("throughput_gap2", hs_cyc[6] - hs_cyc[5], 32'd9);
    out_ready = 0;
    send(tbl[1]);
    held = out_sum;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_a = 32'h0005_0000;
      in_b = 32'h0003_0000;
      @(posedge clk); #1;
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_out_sum", out_sum, held);
    end
    in_valid = 0;
    out_ready = 1;
    drain();
    send(tbl[0]);
    drain();
    for (int i = 0; i < 3; i++) begin
      wait_ready();
      in_valid = 1;
      in_a = 32'h0003_0000;
      in_b = 32'h0002_0000;
      @(posedge clk); #1;
    end
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_out_sum", out_sum, 32'd0);
    chk("mid_rst_out_ovf", {31'b0, out_ovf}, 32'd0);
    @(posedge clk); #1 rst_n = 1;
    chk("in_ready_after_mid_rst", {31'b0, in_ready}, 32'd1);
    v = fill(32'h0001_0000, 32'h0001_0000, 32'h0008_0000, 1'b0);
    send(v);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
